// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: stage requests and controller outputs; counters present only with PIPE_CTRL_PERF_EN.
interface pipe_ctrl_if;
  logic        if_stall_req;
  logic        id_stall_req;
  logic        ex_stall_req;
  logic        mem_stall_req;
  logic        ex_b_flag;
  logic [31:0] ex_b_target;
  logic [5:0]  stall;
  logic        flush;
  logic        pc_redirect;
  logic [31:0] pc_redirect_addr;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;
  modport master (
    output if_stall_req, id_stall_req, ex_stall_req, mem_stall_req, ex_b_flag, ex_b_target,
    input  stall, flush, pc_redirect, pc_redirect_addr, stall_cycles, flush_count
  );
  modport slave (
    input  if_stall_req, id_stall_req, ex_stall_req, mem_stall_req, ex_b_flag, ex_b_target,
    output stall, flush, pc_redirect, pc_redirect_addr, stall_cycles, flush_count
  );
`else
  modport master (
    output if_stall_req, id_stall_req, ex_stall_req, mem_stall_req, ex_b_flag, ex_b_target,
    input  stall, flush, pc_redirect, pc_redirect_addr
  );
  modport slave (
    input  if_stall_req, id_stall_req, ex_stall_req, mem_stall_req, ex_b_flag, ex_b_target,
    output stall, flush, pc_redirect, pc_redirect_addr
  );
`endif
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall priority, branch flush and PC redirect control.
// Define PIPE_CTRL_PERF_EN to add the stall_cycles / flush_count counters.
module pipe_ctrl (
  input logic        clk,
  input logic        rst,
  pipe_ctrl_if.slave p
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] PEND = 1'b1;
  logic [0:0]  state;
  logic [31:0] tgt_q;
  logic [5:0]  stall_raw;
  logic        accept;
  logic        pend;
  logic        redirect;
  always_comb begin
    stall_raw = p.mem_stall_req ? 6'b011111 :
                p.ex_stall_req  ? 6'b001111 :
                p.id_stall_req  ? 6'b000111 :
                p.if_stall_req  ? 6'b000011 : 6'b000000;
    accept    = !rst && state == IDLE && p.ex_b_flag && !stall_raw[3];
    pend      = !rst && state == PEND;
    redirect  = (accept || pend) && !p.if_stall_req;
  end
  assign p.stall            = rst ? 6'b0 : stall_raw;
  assign p.flush            = accept || pend;
  assign p.pc_redirect      = redirect;
  assign p.pc_redirect_addr = !redirect ? 32'h0 : pend ? tgt_q : p.ex_b_target;
  // A branch taken while IF is busy parks its target until IF can accept the redirect.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      tgt_q <= 32'h0;
    end else if (accept && p.if_stall_req) begin
      state <= PEND;
      tgt_q <= p.ex_b_target;
    end else if (pend && !p.if_stall_req)
      state <= IDLE;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      stall_cnt <= 32'h0;
      flush_cnt <= 32'h0;
    end else begin
      if (|p.stall) stall_cnt <= stall_cnt + 32'h1;
      if (accept) flush_cnt <= flush_cnt + 32'h1;
    end
  assign p.stall_cycles = stall_cnt;
  assign p.flush_count  = flush_cnt;
`endif
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL have one clock, clk, and an asynchronous active-high reset, rst; these are the only clock and reset ports.
REQ-002 The block SHALL expose these ports (name, direction, width, meaning):
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- if_stall_req  in  1  IF waiting on instruction memory
- id_stall_req  in  1  load-use hazard detected in ID
- ex_stall_req  in  1  multi-cycle EX operation in progress
- mem_stall_req  in  1  MEM waiting on data memory
- ex_b_flag  in  1  EX resolved a taken branch/jump; held by EX while EX is stalled
- ex_b_target  in  32  branch/jump target address
- stall  out  6  per-stage hold: [0] PC, [1] IF, [2] ID, [3] EX, [4] MEM, [5] WB
- flush  out  1  clear IF/ID and ID/EX to NOP
- pc_redirect  out  1  load PC from pc_redirect_addr this cycle
- pc_redirect_addr  out  32  redirect target
- stall_cycles  out  32  performance counter (PIPE_CTRL_PERF_EN only)
- flush_count  out  32  performance counter (PIPE_CTRL_PERF_EN only)

Function
REQ-003 stall SHALL be combinational, with 0-cycle latency, using this priority:
- mem_stall_req → 6'b011111
- else ex_stall_req → 6'b001111
- else id_stall_req → 6'b000111
- else if_stall_req → 6'b000011
- else → 6'b000000
REQ-004 Consequence of the encoding: id_stall_req alone holds ID and advances EX, which makes ID/EX insert exactly one bubble per cycle.
REQ-005 A branch SHALL be accepted in a cycle where ex_b_flag=1, stall[3]=0 and state=IDLE.
REQ-006 While stall[3]=1, ex_b_flag SHALL be ignored: no flush and no redirect; EX is responsible for re-presenting it.
REQ-007 FSM states SHALL be IDLE and PEND, with a 32-bit register tgt_q.
REQ-008 IDLE, branch accepted, if_stall_req=0: flush=1, pc_redirect=1, pc_redirect_addr=ex_b_target, in the same cycle; stay IDLE.
REQ-009 IDLE, branch accepted, if_stall_req=1: flush=1, pc_redirect=0, tgt_q<=ex_b_target; next state PEND.
REQ-010 PEND, if_stall_req=1: flush=1, pc_redirect=0; stay PEND.
REQ-011 PEND, if_stall_req=0: flush=1, pc_redirect=1, pc_redirect_addr=tgt_q; next state IDLE.
REQ-012 In PEND, ex_b_flag SHALL be ignored; the flush keeps EX empty, so a valid design never raises it there.
REQ-013 In PEND, a concurrent mem_stall_req or ex_stall_req SHALL still drive stall per REQ-003; the flush and redirect rules are unchanged.
REQ-014 When not redirecting, pc_redirect_addr SHALL be 32'h0.
REQ-015 Outside REQ-008 to REQ-011, flush=0 and pc_redirect=0.
REQ-016 tgt_q SHALL be written only on the REQ-009 transition.

Reset
REQ-017 While rst=1, regardless of clk: state=IDLE, tgt_q=32'h0, and both counters = 0.
REQ-018 While rst=1, all outputs SHALL be forced: stall=6'b0, flush=0, pc_redirect=0, pc_redirect_addr=32'h0.
REQ-019 Reset asserted while in PEND SHALL discard the pending target; after release, no redirect occurs until a new branch is accepted.

Configuration
REQ-020 Macro PIPE_CTRL_PERF_EN defined: the block SHALL include two counters, each wrapping from 32'hFFFFFFFF to 0:
- stall_cycles: +1 on every clk edge where stall!=0
- flush_count: +1 on every accepted branch (REQ-008 and REQ-009 only; not per PEND cycle)
REQ-021 Macro PIPE_CTRL_PERF_EN undefined: stall_cycles and flush_count ports and their registers SHALL be absent; all other behaviour is identical.

Verification
REQ-022 The bench SHALL cover these directed scenarios (stimulus → required response):
- Priority: mem_stall_req=1 and id_stall_req=1 → stall=6'b011111; drop mem_stall_req → 6'b000111; drop id_stall_req → 6'b000000.
- Immediate branch: ex_b_flag=1, ex_b_target=32'h0000_0100, no stall requests → same cycle flush=1, pc_redirect=1, pc_redirect_addr=32'h100; next cycle both are 0.
- Deferred branch: ex_b_flag=1 with target 32'h0000_0200 while if_stall_req=1 for 3 cycles → flush=1 for 4 cycles, pc_redirect=0 for 3 cycles, then pc_redirect=1 with addr 32'h200 in the 4th cycle; flush_count increments by exactly 1.
- Blocked branch: ex_b_flag=1 with mem_stall_req=1 → flush=0, pc_redirect=0, stall=6'b011111; release mem_stall_req with ex_b_flag still 1 → redirect in that cycle.
- Reset mid-PEND: enter PEND with target 32'h300, assert rst asynchronously between clock edges → outputs 0 immediately; release with if_stall_req=0 → pc_redirect never asserts.
- Counter wrap (PIPE_CTRL_PERF_EN): force stall_cycles to 32'hFFFFFFFF, hold if_stall_req=1 for one edge → stall_cycles=0.
